conv_row_mac: RTL and testbench
===============================

CONV_ROW_MAC -- requirements
Module: conv_row_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning signed sample and weight width.
REQ-002 SHALL have parameter ACC_W, default 16, meaning signed output width.
REQ-003 SHALL have parameter TAPS, default 3, range 2..9, meaning kernel row length.
REQ-004 SHALL have parameter LINE_LEN, default 480, meaning samples per image line.
REQ-005 SHALL have port clk, input, 1 bit, single clock; all logic updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port ce, input, 1 bit, clock enable; ce=0 freezes all state.
REQ-008 SHALL have port din_valid, input, 1 bit, sample strobe.
REQ-009 SHALL have port din, input, DATA_W bits signed, pixel sample.
REQ-010 SHALL have port weight_load, input, 1 bit, weight capture strobe.
REQ-011 SHALL have port weight_in, input, TAPS*DATA_W bits; tap k at [k*DATA_W +: DATA_W].
REQ-012 SHALL have port dout_valid, output, 1 bit, result strobe.
REQ-013 SHALL have port dout, output, ACC_W bits signed, filtered sample.
REQ-014 SHALL have port line_last, output, 1 bit, high with dout_valid for the last result of a line.

Function
REQ-015 Sample accepted only when ce=1 and din_valid=1.
REQ-016 Weights captured into TAPS registers when ce=1 and weight_load=1; a sample accepted the same cycle uses the old weights.
REQ-017 Result for accepted sample n: y[n] = sum over k=0..TAPS-1 of w[k]*x[n-k]; tap 0 = newest sample.
REQ-018 Samples with index n-k < 0 within the current line count as zero (left zero padding); no history crosses a line boundary.
REQ-019 Column counter 0..LINE_LEN-1 advances per accepted sample and wraps to 0 after LINE_LEN-1; the wrap clears the delay line history.
REQ-020 Pipeline: stage 1 registers TAPS products (2*DATA_W bits), stage 2 registers sum; latency 2 ce-enabled cycles from acceptance to dout_valid.
REQ-021 Internal sum width SHALL be 2*DATA_W+ceil(log2(TAPS)), so no intermediate overflow.
REQ-022 Pipeline valid bits advance only when ce=1; ce=0 holds dout, dout_valid, line_last unchanged.
REQ-023 Gaps in din_valid insert bubbles; dout_valid=0 for bubbles; dout holds last value.
REQ-024 line_last is the pipelined image of "column counter = LINE_LEN-1" at acceptance.

Reset
REQ-025 rst_n=0 SHALL immediately clear: dout=0, dout_valid=0, line_last=0, column counter=0, delay line=0, pipeline valids=0, weights=0.
REQ-026 Reset mid-line SHALL discard in-flight results; first sample after release is column 0.

Configuration
REQ-027 Macro CONV_ROW_MAC_SATURATE_EN defined: sum outside ACC_W range clamps to max 2^(ACC_W-1)-1 or min -2^(ACC_W-1).
REQ-028 Macro undefined: dout is the low ACC_W bits of the sum (two's-complement wrap).

Structure
REQ-029 Package conv_pkg SHALL hold default DATA_W, ACC_W, TAPS, LINE_LEN constants and the sum-width function.
REQ-030 Sub-module conv_tap_mul SHALL implement one registered signed multiply, instantiated TAPS times.

Verification
REQ-031 Weights 1,2,3, din ramp 1..480 continuous, ce=1 -> dout 1,4,10,16,22,... (6n-2 for n>=2), dout_valid two cycles after each sample.
REQ-032 Second line ramp 1..480 -> first outputs again 1,4,10 (padding, no history from previous line); line_last high only with result for column 479.
REQ-033 din=127, weights 127,127,127, column>=2 -> dout=32767 with SATURATE_EN; -17149 without.
REQ-034 ce=0 for 5 cycles mid-line -> outputs frozen, no sample lost, results resume as 6n-2 sequence.
REQ-035 weight_load with weights 1,1,1 at column 100 -> samples accepted after load give x[n]+x[n-1]+x[n-2]; the sample accepted in the load cycle uses 1,2,3.
REQ-036 rst_n pulsed low at column 200 -> dout, dout_valid, line_last 0 immediately; next sample treated as column 0 with zero history.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared defaults and width helper for the conv_row_mac filter.
// Holds the default parameters and the sum width function.
package conv_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ACC_W    = 16;
  localparam int DEF_TAPS     = 3;
  localparam int DEF_LINE_LEN = 480;

  // Width that holds the sum of TAPS full-width products
  // without overflow.
  function automatic int sum_w(
    input int dw,
    input int taps
  );
    return 2 * dw + $clog2(taps);
  endfunction

endpackage

// File: rtl/conv_tap_mul.sv
// One registered signed multiply (one kernel tap).
// Ports: clk, rst_n, en, a, b -> p (2*DATA_W, registered).
module conv_tap_mul #(
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] p
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (en) begin
      p <= a * b;
    end
  end

endmodule

// File: rtl/conv_row_mac.sv
// Row convolution MAC: y[n] = sum w[k]*x[n-k], zero padded per line.
// Ports: clk, rst_n, ce, din_valid, din, weight_load, weight_in,
//        dout_valid, dout, line_last.
// Define CONV_ROW_MAC_SATURATE_EN to clamp dout instead of wrapping.
module conv_row_mac
  import conv_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int TAPS     = DEF_TAPS,
  parameter int LINE_LEN = DEF_LINE_LEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     din_valid,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     weight_load,
  input  logic [TAPS*DATA_W-1:0]   weight_in,
  output logic                     dout_valid,
  output logic signed [ACC_W-1:0]  dout,
  output logic                     line_last
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = sum_w(DATA_W, TAPS);
  localparam int MW = (SW > ACC_W) ? SW : ACC_W;
  localparam int CW =
    (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [CW-1:0] COL_END =
    CW'(LINE_LEN - 1);

  logic                     acc_in;
  logic                     wld;
  logic [CW-1:0]            col;
  logic                     col_end;
  logic signed [DATA_W-1:0] w    [TAPS];
  logic signed [DATA_W-1:0] hist [TAPS-1];
  logic signed [DATA_W-1:0] x    [TAPS];
  logic signed [PW-1:0]     prod [TAPS];
  logic                     v1;
  logic                     last1;
  logic signed [MW-1:0]     sum;
  logic signed [ACC_W-1:0]  res;

  assign acc_in  = ce & din_valid;
  assign wld     = ce & weight_load;
  assign col_end = (col == COL_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) w[k] <= '0;
    end else if (wld) begin
      for (int k = 0; k < TAPS; k++)
        w[k] <= weight_in[k*DATA_W +: DATA_W];
    end
  end

  // The last sample of a line leaves an empty history, so the
  // next line starts with zero padding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      for (int k = 0; k < TAPS-1; k++) hist[k] <= '0;
    end else if (acc_in) begin
      if (col_end) begin
        col <= '0;
        for (int k = 0; k < TAPS-1; k++) hist[k] <= '0;
      end else begin
        col     <= col + 1'b1;
        hist[0] <= din;
        for (int k = 1; k < TAPS-1; k++)
          hist[k] <= hist[k-1];
      end
    end
  end

  always_comb begin
    x[0] = din;
    for (int k = 1; k < TAPS; k++) x[k] = hist[k-1];
  end

  for (genvar g = 0; g < TAPS; g++) begin : g_tap
    conv_tap_mul #(
      .DATA_W (DATA_W)
    ) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (acc_in),
      .a     (x[g]),
      .b     (w[g]),
      .p     (prod[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
    end else if (ce) begin
      v1    <= din_valid;
      last1 <= din_valid & col_end;
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++)
      sum = sum + MW'(prod[k]);
  end

`ifdef CONV_ROW_MAC_SATURATE_EN
  localparam logic signed [MW-1:0] MAXV =
    {{(MW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [MW-1:0] MINV = ~MAXV;

  always_comb begin
    if (sum > MAXV)      res = ACC_W'(MAXV);
    else if (sum < MINV) res = ACC_W'(MINV);
    else                 res = ACC_W'(sum);
  end
`else
  always_comb res = ACC_W'(sum);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      line_last  <= 1'b0;
    end else if (ce) begin
      dout_valid <= v1;
      line_last  <= v1 & last1;
      if (v1) dout <= res;
    end
  end

endmodule

// File: tb/tb_conv_row_mac.sv
// Scoreboard bench for conv_row_mac (default parameters).
// Driver feeds a line-level reference model; monitor checks outputs.
module tb_conv_row_mac;

  localparam int LINE = 480;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ce;
  logic               din_valid;
  logic signed [7:0]  din;
  logic               weight_load;
  logic [23:0]        weight_in;
  logic               dout_valid;
  logic signed [15:0] dout;
  logic               line_last;

  conv_row_mac dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .din_valid   (din_valid),
    .din         (din),
    .weight_load (weight_load),
    .weight_in   (weight_in),
    .dout_valid  (dout_valid),
    .dout        (dout),
    .line_last   (line_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] v;
    bit                 last;
    int                 tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // reference model state
  int xs [LINE];
  int col = 0;
  int mw [3] = '{0, 0, 0};

  // monitor state
  int                 ce_edges = 0;
  bit                 ce_at_edge = 0;
  bit                 mon_en = 0;
  logic signed [15:0] hold_v = 0;
  bit                 hold_valid = 0;
  bit                 hold_last = 0;

  function automatic logic signed [15:0] fix(int y);
`ifdef CONV_ROW_MAC_SATURATE_EN
    if (y > 32767)  return 16'sh7fff;
    if (y < -32768) return 16'sh8000;
`endif
    return 16'(y);
  endfunction

  function automatic void accept(int d);
    int   y;
    exp_t e;
    xs[col] = d;
    y = 0;
    for (int k = 0; k < 3; k++)
      if (col - k >= 0) y += mw[k] * xs[col-k];
    e.v    = fix(y);
    e.last = (col == LINE - 1);
    e.tag  = ce_edges + 2;
    sb.push_back(e);
    col = (col + 1) % LINE;
  endfunction

  task automatic cyc(
    input bit c, input bit v, input int d,
    input bit wl, input int w0, input int w1, input int w2
  );
    @(negedge clk);
    ce          = c;
    din_valid   = v;
    din         = 8'(d);
    weight_load = wl;
    weight_in   = {8'(w2), 8'(w1), 8'(w0)};
    if (c && v) accept(int'(din));
    if (c && wl)
      for (int k = 0; k < 3; k++)
        mw[k] = int'($signed(weight_in[k*8 +: 8]));
  endtask

  task automatic chk_zero(input string nm);
    tests++;
    if (dout !== 0 || dout_valid !== 0 || line_last !== 0) begin
      fails++;
      $display("FAIL %s: dout=%0d v=%b last=%b, need 0 0 0",
               nm, dout, dout_valid, line_last);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    ce = 1'b0;
    din_valid = 1'b0;
    weight_load = 1'b0;
    #1;
    chk_zero(nm);
    sb.delete();
    col = 0;
    mw = '{0, 0, 0};
    hold_v = 0;
    hold_valid = 0;
    hold_last = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    ce_at_edge = ce && rst_n;
    if (ce_at_edge) ce_edges++;
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (ce_at_edge) begin
        bit   ev;
        exp_t e;
        while (sb.size() > 0 && sb[0].tag < ce_edges) begin
          e = sb.pop_front();
          tests++;
          fails++;
          $display("FAIL missing: result %0d not seen, need it",
                   e.v);
        end
        ev = sb.size() > 0 && sb[0].tag == ce_edges;
        tests++;
        if (dout_valid !== ev) begin
          fails++;
          $display("FAIL valid: dout_valid=%b, need %b",
                   dout_valid, ev);
        end else if (ev) begin
          e = sb.pop_front();
          if (dout !== e.v || line_last !== e.last) begin
            fails++;
            $display("FAIL result: dout=%0d last=%b, need %0d %b",
                     dout, line_last, e.v, e.last);
          end
          hold_v = e.v;
          hold_last = e.last;
        end else if (dout !== hold_v || line_last !== 1'b0) begin
          fails++;
          $display("FAIL bubble: dout=%0d last=%b, need %0d 0",
                   dout, line_last, hold_v);
        end
        hold_valid = ev;
        if (!ev) hold_last = 0;
      end else begin
        tests++;
        if (dout !== hold_v || dout_valid !== hold_valid ||
            line_last !== hold_last) begin
          fails++;
          $display("FAIL freeze: dout=%0d v=%b l=%b, need %0d %b %b",
                   dout, dout_valid, line_last,
                   hold_v, hold_valid, hold_last);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ce = 1'b0;
    din_valid = 1'b0;
    din = '0;
    weight_load = 1'b0;
    weight_in = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    mon_en = 1;

    // weights 1,2,3; ramp line with a 5-cycle ce stall
    cyc(1, 0, 0, 1, 1, 2, 3);
    for (int i = 0; i < LINE; i++) begin
      if (i == 240)
        repeat (5) cyc(0, 1, $urandom_range(0, 255), 0, 0, 0, 0);
      cyc(1, 1, i + 1, 0, 0, 0, 0);
    end

    // second line; weights 1,1,1 loaded with sample at column 100
    for (int i = 0; i < LINE; i++) begin
      if (i == 100) cyc(1, 1, i + 1, 1, 1, 1, 1);
      else          cyc(1, 1, i + 1, 0, 0, 0, 0);
    end

    // overflow line: 127 * 127 on every tap, some gaps
    cyc(1, 0, 0, 1, 127, 127, 127);
    for (int i = 0; i < LINE; i++) begin
      if (i % 37 == 5) cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 127, 0, 0, 0, 0);
    end

    // random traffic
    for (int i = 0; i < 1600; i++) begin
      cyc($urandom_range(0, 9) != 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 255),
          $urandom_range(0, 31) == 0,
          $urandom_range(0, 255),
          $urandom_range(0, 255),
          $urandom_range(0, 255));
    end

    // reset at column 200 with results in flight
    do_reset("reset_align");
    cyc(1, 0, 0, 1, 1, 2, 3);
    for (int i = 0; i < 200; i++) cyc(1, 1, i + 1, 0, 0, 0, 0);
    do_reset("reset_mid");
    cyc(1, 0, 0, 1, 1, 2, 3);
    for (int i = 0; i < 12; i++) cyc(1, 1, i + 1, 0, 0, 0, 0);

    // drain with a bounded wait
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && sb.size() != 0; i++)
      @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results pending, need 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
